lfsr_stream_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random source with valid/ready output and seed load.

---
 rtl/lfsr_pkg.sv | 42 ++++
 rtl/lfsr_stream_gen_if.sv | 32 +++
 rtl/hex_seg_dec.sv | 23 ++
 rtl/lfsr_stream_gen.sv | 182 ++++++++++++++++++
 tb/tb_lfsr_stream_gen.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the LFSR stream generator: FSM state
//                encoding, default feedback/seed constants and the hex to
//                seven-segment lookup table (active-low, {g,f,e,d,c,b,a}).
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } fsm_state_t;

    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0] c_default_taps = 8'h1D;
    localparam logic [7:0] c_default_seed = 8'h01;

    // Entry n holds the segment pattern for hex digit n.
    localparam logic [15:0][6:0] c_seg_table = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage
`default_nettype wire

// File: rtl/lfsr_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_stream_gen_if
//  Description : Valid/ready output stream of the LFSR generator.
//                  out_data  - current LFSR state offered to the consumer
//                  out_valid - out_data is offered
//                  out_ready - consumer accepts out_data this cycle
//                Modports: master (generator side), slave (consumer side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_stream_gen_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/hex_seg_dec.sv
`default_nettype none
// ============================================================================
//  Module      : hex_seg_dec
//  Description : Combinational 4-bit to seven-segment decoder, active-low,
//                output order {g,f,e,d,c,b,a}. Only built when LFSR_SEG_EN
//                is defined.
//  Ports       : nibble (in, 4) - hex digit
//                seg    (out, 7) - segment pattern
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef LFSR_SEG_EN
module hex_seg_dec
    import lfsr_pkg::*;
(
    input  wire logic [3:0] nibble,
    output logic      [6:0] seg
);

    assign seg = c_seg_table[nibble];

endmodule
`endif
`default_nettype wire

// File: rtl/lfsr_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_stream_gen
//  Description : Fibonacci LFSR pseudo-random source with valid/ready output,
//                seed load, free-run / counted-burst modes, all-zero lockup
//                recovery and cycle-length (period) measurement.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load, seed      - load seed into state (zero -> SEED)
//                free_run        - level, run continuously while high
//                start, burst_len- start a counted burst (ignored while busy)
//                stream          - valid/ready output (master modport)
//                busy            - FSM not IDLE
//                done            - pulse, burst complete
//                wrap            - pulse, state returned to anchor
//                lockup          - pulse, zero seed replaced by SEED
//                period          - last measured cycle length
//                seg             - registered 7-seg readout (LFSR_SEG_EN only)
//  Macro       : LFSR_SEG_EN - adds the seg output and digit decoders
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_default_taps),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(c_default_seed),
    parameter int               CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] seed,
    input  wire logic             free_run,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] burst_len,
    lfsr_stream_gen_if.master     stream,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic                  lockup,
    output logic      [CNT_W-1:0] period
`ifdef LFSR_SEG_EN
    ,
    output logic [7*((WIDTH+3)/4)-1:0] seg
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    fsm_state_t       r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_anchor;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_remaining;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_valid;
    logic             w_xfer;

    assign w_next      = {^(r_state & TAPS), r_state[WIDTH-1:1]};
    assign w_valid     = (r_fsm != IDLE);
    assign w_xfer      = w_valid & stream.out_ready;
    assign w_count_inc = (r_count == c_cnt_max) ? r_count : r_count + CNT_W'(1);

    assign stream.out_data  = r_state;
    assign stream.out_valid = w_valid;
    assign busy             = w_valid;

    // State, anchor and period measurement. A load overrides a step but the
    // transfer it coincides with is still counted by the FSM below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SEED;
            r_anchor <= SEED;
            r_count  <= '0;
            period   <= '0;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                r_count <= '0;
                if (seed == '0) begin
                    // An all-zero state would never leave zero.
                    r_state  <= SEED;
                    r_anchor <= SEED;
                    lockup   <= 1'b1;
                end else begin
                    r_state  <= seed;
                    r_anchor <= seed;
                end
            end else if (w_xfer) begin
                r_state <= w_next;
                if (w_next == r_anchor) begin
                    wrap    <= 1'b1;
                    period  <= w_count_inc;
                    r_count <= '0;
                end else begin
                    r_count <= w_count_inc;
                end
            end
        end
    end

    // Mode control: free-run, counted burst, zero-length burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_remaining <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (free_run) begin
                        r_fsm <= RUN;
                    end else if (start) begin
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            r_remaining <= burst_len;
                            r_fsm       <= BURST;
                        end
                    end
                end
                RUN: begin
                    if (!free_run) begin
                        r_fsm <= IDLE;
                    end
                end
                BURST: begin
                    if (w_xfer) begin
                        if (r_remaining == CNT_W'(1)) begin
                            r_fsm <= IDLE;
                            done  <= 1'b1;
                        end
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_SEG_EN
    localparam int c_ndig = (WIDTH + 3) / 4;

    logic [4*c_ndig-1:0] w_state_pad;
    logic [4*c_ndig-1:0] w_seed_pad;
    logic [7*c_ndig-1:0] w_seg;
    logic [7*c_ndig-1:0] w_seed_seg;

    assign w_state_pad = (4*c_ndig)'(r_state);
    assign w_seed_pad  = (4*c_ndig)'(SEED);

    // The seed decoders see a constant and reduce to the reset pattern.
    for (genvar d = 0; d < c_ndig; d++) begin : g_digit
        hex_seg_dec u_state_dec (
            .nibble (w_state_pad[4*d +: 4]),
            .seg    (w_seg[7*d +: 7])
        );
        hex_seg_dec u_seed_dec (
            .nibble (w_seed_pad[4*d +: 4]),
            .seg    (w_seed_seg[7*d +: 7])
        );
    end

    // Readout lags the state register by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= w_seed_seg;
        end else begin
            seg <= w_seg;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_stream_gen
//  Description : Self-checking bench for lfsr_stream_gen. An 8-bit instance
//                with default parameters is driven through vector tables and
//                hand-written sequences; a 4-bit instance (TAPS=3, SEED=1)
//                has its period measured. Seven-segment checks are compiled
//                in with LFSR_SEG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [7:0]  seed;
    logic        free_run;
    logic        start;
    logic [15:0] burst_len;
    logic        busy, done, wrap, lockup;
    logic [15:0] period;

    logic        free_run4;
    logic        busy4, done4, wrap4, lockup4;
    logic [15:0] period4;

`ifdef LFSR_SEG_EN
    logic [13:0] seg8;
    logic [6:0]  seg4;
`endif

    int n_total = 0;
    int n_pass  = 0;

    lfsr_stream_gen_if #(.WIDTH(8)) s8 ();
    lfsr_stream_gen_if #(.WIDTH(4)) s4 ();

    lfsr_stream_gen u_dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .seed      (seed),
        .free_run  (free_run),
        .start     (start),
        .burst_len (burst_len),
        .stream    (s8),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .lockup    (lockup),
        .period    (period)
`ifdef LFSR_SEG_EN
        ,
        .seg       (seg8)
`endif
    );

    lfsr_stream_gen #(
        .WIDTH (4),
        .TAPS  (4'h3),
        .SEED  (4'h1),
        .CNT_W (16)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .seed      (4'h0),
        .free_run  (free_run4),
        .start     (1'b0),
        .burst_len (16'd0),
        .stream    (s4),
        .busy      (busy4),
        .done      (done4),
        .wrap      (wrap4),
        .lockup    (lockup4),
        .period    (period4)
`ifdef LFSR_SEG_EN
        ,
        .seg       (seg4)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       free_run;
        logic       out_ready;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int xfers;
        int done_cnt;
        int seen;

        // free_run, out_ready, expected out_data and out_valid after the edge
        vecs[0]  = '{1'b1, 1'b1, 8'h01, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 8'h80, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'h40, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'h40, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'h40, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h40, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'h20, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'h10, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h88, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'hC4, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'hC4, 1'b0};

        load = 1'b0; seed = 8'h00; free_run = 1'b0; start = 1'b0;
        burst_len = 16'd0; s8.out_ready = 1'b0;
        free_run4 = 1'b0; s4.out_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_data",   32'(s8.out_data),  32'h01);
        chk("rst_valid",  32'(s8.out_valid), 32'h0);
        chk("rst_busy",   32'(busy),         32'h0);
        chk("rst_done",   32'(done),         32'h0);
        chk("rst_wrap",   32'(wrap),         32'h0);
        chk("rst_lockup", 32'(lockup),       32'h0);
        chk("rst_period", 32'(period),       32'h0);
`ifdef LFSR_SEG_EN
        chk("rst_seg", 32'(seg8), 32'({7'b1000000, 7'b1111001}));
`endif

        // Free run with a 3-cycle stall at 0x40, then stop mid-transfer
        for (int i = 0; i < 11; i++) begin
            free_run     = vecs[i].free_run;
            s8.out_ready = vecs[i].out_ready;
            tick();
            chk($sformatf("vec%0d_data", i),  32'(s8.out_data),  32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_valid", i), 32'(s8.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_busy", i),  32'(busy),         32'(vecs[i].exp_valid));
        end

        // Full cycle: wrap after 255 transfers, period 255
        do_reset();
        free_run = 1'b1; s8.out_ready = 1'b1;
        tick();
        n = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (wrap) begin seen = 1; break; end
        end
        chk("wrap_seen",   32'(seen),         32'd1);
        chk("wrap_steps",  32'(n),            32'd255);
        chk("wrap_period", 32'(period),       32'd255);
        chk("wrap_data",   32'(s8.out_data),  32'h01);
        tick();
        chk("wrap_pulse",  32'(wrap),         32'd0);
        free_run = 1'b0;
        tick();

        // Burst of 5 with a start pulse re-issued mid-burst (ignored)
        do_reset();
        start = 1'b1; burst_len = 16'd5;
        tick();
        start = 1'b0;
        chk("burst_busy", 32'(busy), 32'd1);
        xfers = 0; done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (s8.out_valid && s8.out_ready) xfers++;
            start = (c == 1);
            burst_len = (c == 1) ? 16'd9 : 16'd5;
            tick();
            if (done) done_cnt++;
            if (!busy) break;
        end
        start = 1'b0;
        chk("burst_xfers", 32'(xfers),        32'd5);
        chk("burst_done",  32'(done_cnt),     32'd1);
        chk("burst_data",  32'(s8.out_data),  32'h88);
        tick();
        chk("burst_done_pulse", 32'(done), 32'd0);
        chk("burst_idle",       32'(busy), 32'd0);

        // Zero-length burst: done, no transfer
        start = 1'b1; burst_len = 16'd0;
        tick();
        start = 1'b0;
        chk("zlen_done",  32'(done),         32'd1);
        chk("zlen_busy",  32'(busy),         32'd0);
        chk("zlen_data",  32'(s8.out_data),  32'h88);
        tick();
        chk("zlen_done_pulse", 32'(done), 32'd0);

        // Zero seed -> SEED with lockup pulse
        load = 1'b1; seed = 8'h00;
        tick();
        load = 1'b0;
        chk("lock_data", 32'(s8.out_data), 32'h01);
        chk("lock_flag", 32'(lockup),      32'd1);
        tick();
        chk("lock_pulse", 32'(lockup), 32'd0);

        // Load 0xA5 during a burst of 4; the load cycle transfer still counts
        start = 1'b1; burst_len = 16'd4;
        tick();
        start = 1'b0;
        tick();
        chk("ldb_first", 32'(s8.out_data), 32'h80);
        load = 1'b1; seed = 8'hA5;
        tick();
        load = 1'b0;
        chk("ldb_data", 32'(s8.out_data), 32'hA5);
        chk("ldb_busy", 32'(busy),        32'd1);
        xfers = 0; done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (s8.out_valid && s8.out_ready) xfers++;
            tick();
            if (done) done_cnt++;
            if (!busy) break;
        end
        chk("ldb_xfers", 32'(xfers),        32'd2);
        chk("ldb_done",  32'(done_cnt),     32'd1);
        chk("ldb_final", 32'(s8.out_data),  32'hA9);

`ifdef LFSR_SEG_EN
        // Seven-segment readout lags state by one cycle
        load = 1'b1; seed = 8'h80;
        tick();
        load = 1'b0;
        chk("seg_state", 32'(s8.out_data), 32'h80);
        chk("seg_lag",   32'(seg8), 32'({7'b0001000, 7'b0010000}));
        tick();
        chk("seg_hi", 32'(seg8[13:7]), 32'(7'b0000000));
        chk("seg_lo", 32'(seg8[6:0]),  32'(7'b1000000));
`endif

        // Reset in the middle of a burst: no done afterwards
        start = 1'b1; burst_len = 16'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_data",   32'(s8.out_data),  32'h01);
        chk("mrst_valid",  32'(s8.out_valid), 32'd0);
        chk("mrst_busy",   32'(busy),         32'd0);
        chk("mrst_done",   32'(done),         32'd0);
        chk("mrst_period", 32'(period),       32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        chk("mrst_quiet", 32'(done_cnt), 32'd0);

        // 4-bit instance: period 15
        free_run4 = 1'b1; s4.out_ready = 1'b1;
        tick();
        chk("w4_first", 32'(s4.out_data), 32'h1);
        n = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (wrap4) begin seen = 1; break; end
        end
        chk("w4_seen",   32'(seen),    32'd1);
        chk("w4_steps",  32'(n),       32'd15);
        chk("w4_period", 32'(period4), 32'd15);
        free_run4 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
